// File: rtl/uart_tx_if.sv
// Producer-side byte handshake for uart_tx: data_in is taken on a rising edge with valid && ready.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter (8 data bits, optional parity, 1-2 stop bits); start bit appears one cycle after accept.
// ready drops while the one-entry holding register is full; a held byte starts right after the last stop bit.
module uart_tx #(
    parameter int BAUD_RATE    = 9_600,
    parameter int SYS_CLK_FREQ = 48_000_000,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
    localparam int TW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(BIT_PERIOD - 1);
    localparam bit PAR_EN     = (PARITY != 0);
    localparam bit PAR_ODD    = (PARITY == 1);
    localparam bit TWO_STOP   = (STOP_BITS == 2);

    generate
        if (BIT_PERIOD < 2) begin : g_bad_period
            $error("uart_tx: SYS_CLK_FREQ / BAUD_RATE must be at least 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          state_q,     state_d;
    logic [TW-1:0]   timer_q,     timer_d;
    logic [7:0]      shift_q,     shift_d;
    logic [2:0]      bit_idx_q,   bit_idx_d;
    logic            stop_cnt_q,  stop_cnt_d;
    logic            parity_q,    parity_d;
    logic            tx_q,        tx_d;
    logic [7:0]      hold_data_q, hold_data_d;
    logic            hold_full_q, hold_full_d;

    logic            accept;
    logic            timer_done;

    assign accept     = bus.valid && !hold_full_q;
    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;

        if (accept) begin
            hold_data_d = bus.data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_data_q;
                    parity_d    = PAR_ODD ? ~(^hold_data_q) : ^hold_data_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    timer_d     = RELOAD;
                    state_d     = S_START;
                end
            end

            S_START: begin
                if (timer_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    timer_d   = RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_DATA: begin
                if (timer_done) begin
                    timer_d = RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        if (PAR_EN) begin
                            tx_d    = parity_q;
                            state_d = S_PAR;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        // shift_q[0] already holds the next data bit after the previous shift
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_PAR: begin
                if (timer_done) begin
                    tx_d       = 1'b1;
                    timer_d    = RELOAD;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_STOP: begin
                if (timer_done) begin
                    if (TWO_STOP && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        timer_d    = RELOAD;
                    end else if (hold_full_q) begin
                        // chain straight into the next start bit so frames stay gap-free
                        shift_d     = hold_data_q;
                        parity_d    = PAR_ODD ? ~(^hold_data_q) : ^hold_data_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                        timer_d     = RELOAD;
                        state_d     = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign bus.ready = ~hold_full_q;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE) | hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop bits) at BIT_PERIOD = 10.
module tb_uart_tx;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] data_r [4];
    logic       valid_r [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] ready_w;

    uart_tx_if if_a ();
    uart_tx_if if_b ();
    uart_tx_if if_c ();
    uart_tx_if if_d ();

    assign if_a.data_in = data_r[0];
    assign if_a.valid   = valid_r[0];
    assign ready_w[0]   = if_a.ready;
    assign if_b.data_in = data_r[1];
    assign if_b.valid   = valid_r[1];
    assign ready_w[1]   = if_b.ready;
    assign if_c.data_in = data_r[2];
    assign if_c.valid   = valid_r[2];
    assign ready_w[2]   = if_c.ready;
    assign if_d.data_in = data_r[3];
    assign if_d.valid   = valid_r[3];
    assign ready_w[3]   = if_d.ready;

    uart_tx #(.BAUD_RATE(4_800_000), .SYS_CLK_FREQ(48_000_000), .PARITY(0), .STOP_BITS(1))
        u_none (.clk(clk), .reset_n(reset_n), .bus(if_a.slave), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.BAUD_RATE(4_800_000), .SYS_CLK_FREQ(48_000_000), .PARITY(2), .STOP_BITS(1))
        u_even (.clk(clk), .reset_n(reset_n), .bus(if_b.slave), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.BAUD_RATE(4_800_000), .SYS_CLK_FREQ(48_000_000), .PARITY(1), .STOP_BITS(1))
        u_odd  (.clk(clk), .reset_n(reset_n), .bus(if_c.slave), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.BAUD_RATE(4_800_000), .SYS_CLK_FREQ(48_000_000), .PARITY(0), .STOP_BITS(2))
        u_stop2 (.clk(clk), .reset_n(reset_n), .bus(if_d.slave), .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends b0 (and b1 queued behind it when two=1), checking tx every cycle of the frame(s).
    task automatic send_frames(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                               input bit two, input bit par_en, input bit p0, input bit p1,
                               input int nstop, input string nm);
        logic [11:0] fb [2];
        int nbits;
        int flen;
        int total;
        nbits = 10 + (par_en ? 1 : 0) + nstop - 1;
        flen  = nbits * 10;
        total = two ? 2 * flen : flen;
        fb[0] = '1;
        fb[0][0] = 1'b0;
        fb[0][8:1] = b0;
        if (par_en) fb[0][9] = p0;
        fb[1] = '1;
        fb[1][0] = 1'b0;
        fb[1][8:1] = b1;
        if (par_en) fb[1][9] = p1;

        @(negedge clk);
        data_r[idx]  = b0;
        valid_r[idx] = 1'b1;
        @(posedge clk);
        #1 valid_r[idx] = 1'b0;
        check({nm, " ready after accept"}, ready_w[idx], 0);
        check({nm, " busy after accept"}, busy_w[idx], 1);
        check({nm, " tx before start"}, tx_w[idx], 1);

        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("%s tx k=%0d", nm, k), tx_w[idx], fb[k / flen][(k % flen) / 10]);
            if (k == 0) begin
                check({nm, " ready after load"}, ready_w[idx], 1);
                if (two) begin
                    data_r[idx]  = b1;
                    valid_r[idx] = 1'b1;
                end
            end
            if (two && k == 1) begin
                valid_r[idx] = 1'b0;
                check({nm, " ready after second accept"}, ready_w[idx], 0);
            end
            if (two && k == 2) begin
                data_r[idx]  = 8'h55;
                valid_r[idx] = 1'b1;
            end
            if (two && k == 5) begin
                check({nm, " ready while held"}, ready_w[idx], 0);
                valid_r[idx] = 1'b0;
            end
            if (two && k == flen - 1) check({nm, " ready end of frame 1"}, ready_w[idx], 0);
            if (two && k == flen)     check({nm, " ready after chain load"}, ready_w[idx], 1);
            if (k == total - 1)       check({nm, " busy last cycle"}, busy_w[idx], 1);
        end
        @(posedge clk);
        #2;
        check({nm, " busy after frame"}, busy_w[idx], 0);
        check({nm, " tx idle after frame"}, tx_w[idx], 1);
        check({nm, " ready idle"}, ready_w[idx], 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        for (int i = 0; i < 4; i++) begin
            data_r[i]  = 8'h00;
            valid_r[i] = 1'b0;
        end

        // asynchronous reset with no clock edge in between
        #1 reset_n = 1'b0;
        #2;
        check("reset tx", tx_w, 4'hF);
        check("reset ready", ready_w, 4'hF);
        check("reset busy", busy_w, 4'h0);
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h11;
        repeat (3) @(posedge clk);
        #2;
        check("reset held ready", ready_w, 4'hF);
        check("reset held busy", busy_w, 4'h0);
        valid_r[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("post reset tx", tx_w, 4'hF);

        send_frames(0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "a5");
        send_frames(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1, "b2b");
        send_frames(1, 8'h07, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1, "even");
        send_frames(2, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, "odd");
        send_frames(3, 8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 2, "stop2");

        // abort mid-frame (during d3 of 0x3C) with 0x99 pending
        fr = {1'b1, 8'h3C, 1'b0};
        @(negedge clk);
        data_r[0]  = 8'h3C;
        valid_r[0] = 1'b1;
        @(posedge clk);
        #1 valid_r[0] = 1'b0;
        for (int k = 0; k <= 44; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("abort tx k=%0d", k), tx_w[0], fr[k / 10]);
            if (k == 0) begin
                data_r[0]  = 8'h99;
                valid_r[0] = 1'b1;
            end
            if (k == 1) begin
                valid_r[0] = 1'b0;
                check("abort pending ready", ready_w[0], 0);
            end
        end
        reset_n = 1'b0;
        #1;
        check("abort tx", tx_w[0], 1);
        check("abort ready", ready_w[0], 1);
        check("abort busy", busy_w[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("abort pending lost busy", busy_w[0], 0);
        check("abort pending lost tx", tx_w[0], 1);

        send_frames(0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "x81");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
